// File: rtl/pc_unit.sv
// Program counter with RUN/HALTED control, prioritised redirects, a sticky
// sequential-wrap flag and a one-cycle registered redirect indication.
module pc_unit #(
  parameter int                  PC_WIDTH  = 12,
  parameter int                  OUT_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 jump_en,
  input  logic [PC_WIDTH-1:0]  jump_target,
  input  logic                 branch_en,
  input  logic [PC_WIDTH-1:0]  branch_offset,
  input  logic                 halt,
  input  logic                 resume,
  output logic [OUT_WIDTH-1:0] pc,
  output logic [OUT_WIDTH-1:0] pc_plus1,
  output logic                 halted,
  output logic                 wrapped,
  output logic                 redirect
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t              state_p0, state_nxt;
  logic [PC_WIDTH-1:0] pc_p0, pc_nxt, pc_inc;
  logic                redirect_p0, wrapped_p0;
  logic                take_redirect, seq_wrap;

  // Modulo-2^PC_WIDTH add of a two's-complement offset; overflow wraps silently.
  function automatic logic [PC_WIDTH-1:0] wrap_add(
    input logic [PC_WIDTH-1:0]        base,
    input logic signed [PC_WIDTH-1:0] off
  );
    return base + $unsigned(off);
  endfunction

  assign pc_inc = pc_p0 + PC_WIDTH'(1);

  always_comb begin
    state_nxt     = state_p0;
    pc_nxt        = pc_p0;
    take_redirect = 1'b0;
    seq_wrap      = 1'b0;
    unique case (state_p0)
      RUN: begin
        if (halt) state_nxt = HALTED;
        if (!stall) begin
          if (jump_en) begin
            pc_nxt        = jump_target;
            take_redirect = 1'b1;
          end else if (branch_en) begin
            pc_nxt        = wrap_add(pc_inc, $signed(branch_offset));
            take_redirect = 1'b1;
          end else begin
            pc_nxt   = pc_inc;
            seq_wrap = &pc_p0;
          end
        end
      end
      HALTED: begin
        // PC frozen; resume only returns to RUN, the PC advances a cycle later.
        if (resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Stage p0: architectural PC and control state
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0       <= RESET_PC;
      state_p0    <= RUN;
      redirect_p0 <= 1'b0;
      wrapped_p0  <= 1'b0;
    end else begin
      pc_p0       <= pc_nxt;
      state_p0    <= state_nxt;
      redirect_p0 <= take_redirect;
      if (seq_wrap) wrapped_p0 <= 1'b1;
    end
  end

  assign pc       = OUT_WIDTH'(pc_p0);
  assign pc_plus1 = OUT_WIDTH'(pc_inc);
  assign halted   = (state_p0 == HALTED);
  assign wrapped  = wrapped_p0;
  assign redirect = redirect_p0;

endmodule
